// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
package rr_ring_arbiter_pkg;

    // Arbiter FSM: idle (no grant) or holding one grant.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Index of the set bit of a one-hot vector; 0 for an all-zero vector.
    function automatic int unsigned onehot_to_idx(input logic [63:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_token_ring.sv
// One-hot ring priority pointer. Resets to bit 0 and only moves when loaded.
module rr_token_ring #(
    parameter int N = 4
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_next,
    output logic [N-1:0] o_token
);

    logic [N-1:0] r_token;

    // Token register: async reset to one-hot bit 0, load on grant release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_token <= {{(N-1){1'b0}}, 1'b1};
        end else if (i_load) begin
            r_token <= i_next;
        end
    end

    assign o_token = r_token;

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot token and a per-grant burst
// limit. All outputs are registered; arbitration is combinational.
//
// Handshake: req is level-sensitive. A requester keeps req high until it has
// seen its gnt bit and finished; dropping req releases the grant at the next
// edge. A grant is also released after MAXBURST cycles even if req stays high.
module rr_ring_arbiter
    import rr_ring_arbiter_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAXBURST = 8,
    localparam int IW       = clog2w(N),
    localparam int CW       = clog2w(MAXBURST + 1)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic [N-1:0]  token,
    output logic [CW-1:0] burst_cnt,
    output state_t        dbg_state
);

    state_t        r_state;
    logic [N-1:0]  r_gnt;
    logic [IW-1:0] r_gnt_id;
    logic [CW-1:0] r_burst_cnt;

    state_t        w_state_nxt;
    logic [N-1:0]  w_gnt_nxt;
    logic [IW-1:0] w_gnt_id_nxt;
    logic [CW-1:0] w_burst_cnt_nxt;

    logic [N-1:0]  w_token;
    logic [N-1:0]  w_ring_next;
    logic          w_token_load;
    logic          w_release;
    logic [IW-1:0] w_ptr;
    logic          w_found;
    logic [IW-1:0] w_winner;

    // onehot((i+1) mod N) is simply the current grant rotated left by one.
    assign w_ring_next = {r_gnt[N-2:0], r_gnt[N-1]};

    // Release when the holder drops its request or its burst is used up.
    assign w_release = (r_state == ST_GRANT) &&
                       (!req[r_gnt_id] || (r_burst_cnt == CW'(MAXBURST)));

    // On a release the search already starts from the token's new position.
    assign w_ptr = IW'(onehot_to_idx(64'(w_release ? w_ring_next : w_token)));

    // Priority search: first requester at or above w_ptr, wrapping at N-1.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(w_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_winner = IW'(idx);
            end
        end
    end

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_burst_cnt_nxt = r_burst_cnt;
        w_token_load    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt             = ST_GRANT;
                    w_gnt_nxt               = '0;
                    w_gnt_nxt[w_winner]     = 1'b1;
                    w_gnt_id_nxt            = w_winner;
                    w_burst_cnt_nxt         = CW'(1);
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_token_load = 1'b1;
                    if (w_found) begin
                        w_gnt_nxt           = '0;
                        w_gnt_nxt[w_winner] = 1'b1;
                        w_gnt_id_nxt        = w_winner;
                        w_burst_cnt_nxt     = CW'(1);
                    end else begin
                        w_state_nxt         = ST_IDLE;
                        w_gnt_nxt           = '0;
                        w_gnt_id_nxt        = '0;
                        w_burst_cnt_nxt     = '0;
                    end
                end else begin
                    w_burst_cnt_nxt = r_burst_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_gnt_nxt       = '0;
                w_gnt_id_nxt    = '0;
                w_burst_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state and grant output registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    rr_token_ring #(
        .N (N)
    ) u_token_ring (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_token_load),
        .i_next  (w_ring_next),
        .o_token (w_token)
    );

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign busy      = |r_gnt;
    assign token     = w_token;
    assign burst_cnt = r_burst_cnt;
    assign dbg_state = r_state;

endmodule
